// File: rtl/mullerc_pkg.sv
// Shared C-element definitions: the next-state truth table and watchdog sizing.
// Inputs are passed padded to MAX_N bits; callers set unused bits to 1 in both x and asym.
package mullerc_pkg;

  localparam int MAX_N = 64;

  typedef logic [MAX_N-1:0] vec_t;

  // Rise when every input is high; fall when every symmetric input is low; else hold.
  function automatic logic cel_next(input logic o, input vec_t x, input vec_t asym);
    logic set;
    logic clr;
    set = &x;
    clr = ~|(x & ~asym);
    if (set) begin
      cel_next = 1'b1;
    end else if (clr) begin
      cel_next = 1'b0;
    end else begin
      cel_next = o;
    end
  endfunction

  function automatic int wd_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mullerc_sync_n_sync_chain.sv
// W-bit multi-stage synchroniser with asynchronous active-low reset to RST_VAL.
module sync_chain #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [STAGES];
  logic [W-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/mullerc_sync_n.sv
// Clocked N-input generalised Muller C-element with transition pulses,
// a phase counter and a stall watchdog on the pending half of a handshake.
module mullerc_sync_n
  import mullerc_pkg::*;
#(
  parameter int           N           = 4,
  parameter logic [N-1:0] INV_MASK    = '0,
  parameter logic [N-1:0] ASYM_MASK   = '0,
  parameter logic         RVAL        = 1'b0,
  parameter int           SYNC_STAGES = 2,
  parameter int           CNT_W       = 8,
  parameter int           TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic             en,
  output logic             o,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             stall
);

  localparam int              WD_W      = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0] TIMEOUT_V = WD_W'(TIMEOUT);

  if (N < 1 || N > MAX_N || SYNC_STAGES < 2 || ASYM_MASK == {N{1'b1}}) begin : g_bad_params
    $error("mullerc_sync_n: illegal N, SYNC_STAGES or ASYM_MASK");
  end

  logic [N-1:0]     x;
  vec_t             x_pad;
  vec_t             asym_pad;
  logic             set;
  logic             clr;
  logic             pending;
  logic             o_q, o_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             stall_q, stall_d;

  sync_chain #(
    .W       (N),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ({N{RVAL}})
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in ^ INV_MASK),
    .q   (x)
  );

  always_comb begin
    x_pad              = '1;
    x_pad[N-1:0]       = x;
    asym_pad           = '1;
    asym_pad[N-1:0]    = ASYM_MASK;
    set                = &x;
    clr                = ~|(x & ~ASYM_MASK);
    // Pending: some inputs have moved toward the opposite state but not all of them yet.
    pending            = o_q ? (|(~x & ~ASYM_MASK) & ~clr) : (|x & ~set);

    o_d     = o_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;
    wd_d    = '0;
    if (en) begin
      o_d    = cel_next(o_q, x_pad, asym_pad);
      rise_d = o_d & ~o_q;
      fall_d = ~o_d & o_q;
      if (rise_d || fall_d) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (pending && !(rise_d || fall_d)) begin
        wd_d = (wd_q == TIMEOUT_V) ? wd_q : wd_q + 1'b1;
      end
    end
    stall_d = (TIMEOUT != 0) && (wd_d == TIMEOUT_V);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_q     <= RVAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
      stall_q <= 1'b0;
    end else begin
      o_q     <= o_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      stall_q <= stall_d;
    end
  end

  assign o         = o_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign phase_cnt = cnt_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_mullerc_sync_n.sv
// Randomised scoreboard bench for mullerc_sync_n: a delay-queue reference model
// predicts every cycle's outputs and a monitor compares them after each clock edge.
module tb_mullerc_sync_n;

  localparam int           N       = 4;
  localparam logic [N-1:0] INV     = 4'b0010;
  localparam logic [N-1:0] ASYM    = 4'b1000;
  localparam logic         RVAL    = 1'b0;
  localparam int           SYNC    = 2;
  localparam int           CNT_W   = 3;
  localparam int           TIMEOUT = 8;
  localparam int           NCYC    = 2000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [N-1:0]     in_w = '0;
  logic             o_w;
  logic             rise_w;
  logic             fall_w;
  logic [CNT_W-1:0] cnt_w;
  logic             stall_w;

  mullerc_sync_n #(
    .N           (N),
    .INV_MASK    (INV),
    .ASYM_MASK   (ASYM),
    .RVAL        (RVAL),
    .SYNC_STAGES (SYNC),
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_w),
    .en        (en),
    .o         (o_w),
    .rise      (rise_w),
    .fall      (fall_w),
    .phase_cnt (cnt_w),
    .stall     (stall_w)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             o;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic             stall;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] pipe_m[$];
  logic         o_m;
  int           cnt_m;
  int           run_m;
  int           checks  = 0;
  int           passed  = 0;
  bit           running = 1'b0;
  bit           done    = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Predict the outputs after the next rising edge given that edge's rst/en/in.
  function automatic void model_step(input bit r, input bit e, input logic [N-1:0] raw);
    exp_t         ex;
    logic [N-1:0] x;
    logic [N-1:0] sym_hi;
    logic [N-1:0] sym_lo_bits;
    bit           all_hi;
    bit           sym_lo;
    bit           pend;
    bit           tr;
    ex = '0;
    if (!r) begin
      pipe_m.delete();
      for (int i = 0; i < SYNC; i++) pipe_m.push_front({N{RVAL}});
      o_m   = RVAL;
      cnt_m = 0;
      run_m = 0;
      ex.o  = RVAL;
    end else begin
      x = pipe_m.pop_back();
      pipe_m.push_front(raw ^ INV);
      sym_hi      = x & ~ASYM;
      sym_lo_bits = ~x & ~ASYM;
      all_hi      = (x == {N{1'b1}});
      sym_lo      = (sym_hi == '0);
      pend        = o_m ? (!sym_lo && (sym_lo_bits != '0)) : ((x != '0) && !all_hi);
      tr          = 1'b0;
      if (e) begin
        if (all_hi && !o_m) begin
          o_m = 1'b1; ex.rise = 1'b1; tr = 1'b1;
        end else if (sym_lo && o_m) begin
          o_m = 1'b0; ex.fall = 1'b1; tr = 1'b1;
        end
      end
      if (tr) cnt_m = (cnt_m + 1) % (1 << CNT_W);
      if (!e || !pend || tr) run_m = 0;
      else if (run_m < TIMEOUT) run_m++;
      ex.o     = o_m;
      ex.cnt   = CNT_W'(cnt_m);
      ex.stall = (run_m == TIMEOUT);
    end
    exp_q.push_back(ex);
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("o",         int'(o_w),     int'(e.o));
        chk("rise",      int'(rise_w),  int'(e.rise));
        chk("fall",      int'(fall_w),  int'(e.fall));
        chk("phase_cnt", int'(cnt_w),   int'(e.cnt));
        chk("stall",     int'(stall_w), int'(e.stall));
      end else if (running) begin
        checks++;
        $display("FAIL scoreboard_empty: got no expectation, expected one (t=%0t)", $time);
      end
    end
  end

  // Stimulus
  initial begin
    int           hold  = 0;
    int           ehold = 0;
    logic [N-1:0] xt    = '0;
    bit           e     = 1'b1;
    bit           r;
    #1 rst = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      r = !(c < 3 || (c >= 700 && c < 703) || (c >= 1400 && c < 1402));
      if (hold == 0) begin
        case ($urandom_range(0, 5))
          0:       xt = 4'hF;
          1:       xt = 4'h0;
          2:       xt = ASYM;
          3:       xt = 4'b0001;
          default: xt = N'($urandom);
        endcase
        hold = $urandom_range(1, 14);
      end
      hold--;
      if (ehold == 0) begin
        e     = ($urandom_range(0, 9) != 0);
        ehold = $urandom_range(1, 6);
      end
      ehold--;
      in_w = xt ^ INV;
      en   = e;
      if (rst && !r) begin
        rst = 1'b0;
        #1;
        chk("async_rst_o",     int'(o_w),     int'(RVAL));
        chk("async_rst_cnt",   int'(cnt_w),   0);
        chk("async_rst_stall", int'(stall_w), 0);
      end else begin
        rst = r;
      end
      model_step(r, e, xt ^ INV);
      running = 1'b1;
    end
    @(posedge clk);
    #3;
    done = 1'b1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
